// File: rtl/cop0_regfile_pkg.sv
// CP0 shared definitions: register numbers, exception codes,
// Status/Cause field positions and the access FSM states.
package cop0_regfile_pkg;

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_MOD  = 5'd1,
    EXC_TLBL = 5'd2,
    EXC_TLBS = 5'd3,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_IBE  = 5'd6,
    EXC_DBE  = 5'd7,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_CPU  = 5'd11,
    EXC_OV   = 5'd12,
    EXC_TR   = 5'd13
  } exc_code_e;

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LO  = 8;
  localparam int ST_BEV    = 22;

  localparam int CA_EXC_LO = 2;
  localparam int CA_IP_LO  = 8;
  localparam int CA_TI     = 30;
  localparam int CA_BD     = 31;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_e;

endpackage

// File: rtl/cop0_timer.sv
// CP0 Count/Compare timer with sticky TI.
// Present only when COP0_TIMER_EN is defined; otherwise ties off to 0.
module cop0_timer
  import cop0_regfile_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

`ifdef COP0_TIMER_EN
  logic        phase;
  logic        inc;
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic [31:0] count_nx;
  logic        ti_q;

  assign inc      = (COUNT_DIV == 1) || phase;
  assign count_nx = count_q + 32'd1;

  // divider, counter, compare and sticky match flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase     <= 1'b0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      if (count_we) begin
        count_q <= wdata;
        phase   <= 1'b0;
      end else begin
        phase <= (COUNT_DIV == 1) ? 1'b0 : ~phase;
        if (inc) count_q <= count_nx;
      end
      if (compare_we) begin
        compare_q <= wdata;
        ti_q      <= 1'b0;
      end else if (inc && !count_we
                   && count_nx == compare_q) begin
        ti_q <= 1'b1;
      end
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign ti      = ti_q;
`else
  logic unused_tmr;

  assign unused_tmr = ^{clk, resetn, count_we,
                        compare_we, wdata}
                      ^ (COUNT_DIV == 1);
  assign count   = '0;
  assign compare = '0;
  assign ti      = 1'b0;
`endif

endmodule

// File: rtl/cop0_regfile.sv
// MIPS CP0 register file with MFC0/MTC0 handshake, exception/ERET
// state and interrupt request. Timer optional via COP0_TIMER_EN.
module cop0_regfile
  import cop0_regfile_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_addr,
  input  logic [2:0]  req_sel,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_in_delay,
  input  logic [31:0] exc_badvaddr,
  input  logic        exc_badvaddr_valid,
  input  logic        eret_valid,
  output logic [31:0] epc,
  input  logic [5:0]  hw_int,
  output logic        int_pending,
  output logic        status_exl
);

  state_e      state;
  logic [31:0] rdata_q;

  logic [7:0]  im;
  logic        ie;
  logic        exl;
  logic        bd;
  exc_code_e   exc_q;
  logic [1:0]  ip_sw;
  logic [5:0]  hw_q;
  logic [31:0] epc_q;
  logic [31:0] bva_q;

  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;

  logic        sel0;
  logic        hit_bva;
  logic        hit_count;
  logic        hit_cmp;
  logic        hit_status;
  logic        hit_cause;
  logic        hit_epc;
  logic        accept;
  logic        wr;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;
  logic [7:0]  ip;
  logic [31:0] status_rd;
  logic [31:0] cause_rd;
  logic [31:0] rd_mux;

  assign sel0       = (req_sel == 3'd0);
  assign hit_bva    = sel0 && req_addr == ADDR_BADVADDR;
  assign hit_count  = sel0 && req_addr == ADDR_COUNT;
  assign hit_cmp    = sel0 && req_addr == ADDR_COMPARE;
  assign hit_status = sel0 && req_addr == ADDR_STATUS;
  assign hit_cause  = sel0 && req_addr == ADDR_CAUSE;
  assign hit_epc    = sel0 && req_addr == ADDR_EPC;

  assign accept    = req_valid && state == S_IDLE;
  assign wr        = accept && req_write;
  assign wr_status = wr && hit_status;
  assign wr_cause  = wr && hit_cause;
  assign wr_epc    = wr && hit_epc;

  assign ip = {hw_q[5] | ti, hw_q[4:0], ip_sw};

  cop0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .count_we   (wr && hit_count),
    .compare_we (wr && hit_cmp),
    .wdata      (req_wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  // assemble Status/Cause views and select the MFC0 source
  always_comb begin
    status_rd = '0;
    status_rd[ST_BEV] = 1'b1;
    status_rd[ST_IM_LO +: 8] = im;
    status_rd[ST_EXL] = exl;
    status_rd[ST_IE] = ie;
    cause_rd = '0;
    cause_rd[CA_BD] = bd;
    cause_rd[CA_TI] = ti;
    cause_rd[CA_IP_LO +: 8] = ip;
    cause_rd[CA_EXC_LO +: 5] = exc_q;
    rd_mux = '0;
    unique case (1'b1)
      hit_bva:    rd_mux = bva_q;
      hit_count:  rd_mux = count;
      hit_cmp:    rd_mux = compare;
      hit_status: rd_mux = status_rd;
      hit_cause:  rd_mux = cause_rd;
      hit_epc:    rd_mux = epc_q;
      default:    rd_mux = '0;
    endcase
  end

  // access handshake; read data captured at accept
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      rdata_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (req_valid) begin
          state   <= S_RESP;
          rdata_q <= req_write ? '0 : rd_mux;
        end
        S_RESP: if (resp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status and Cause: exception beats ERET beats MTC0 on EXL
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      im    <= '0;
      ie    <= 1'b0;
      exl   <= 1'b0;
      bd    <= 1'b0;
      exc_q <= EXC_INT;
      ip_sw <= '0;
      hw_q  <= '0;
    end else begin
      hw_q <= hw_int;
      if (wr_status) begin
        im <= req_wdata[ST_IM_LO +: 8];
        ie <= req_wdata[ST_IE];
      end
      if (wr_cause) ip_sw <= req_wdata[CA_IP_LO +: 2];
      if (exc_valid) begin
        exl   <= 1'b1;
        exc_q <= exc_code_e'(exc_code);
        if (!exl) bd <= exc_in_delay;
      end else if (eret_valid) begin
        exl <= 1'b0;
      end else if (wr_status) begin
        exl <= req_wdata[ST_EXL];
      end
    end
  end

  // EPC and BadVAddr; a nested exception keeps the first EPC
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      epc_q <= '0;
      bva_q <= '0;
    end else begin
      if (exc_valid) begin
        if (!exl)
          epc_q <= exc_in_delay ? exc_pc - 32'd4 : exc_pc;
        if (exc_badvaddr_valid) bva_q <= exc_badvaddr;
      end else if (wr_epc) begin
        epc_q <= req_wdata;
      end
    end
  end

  assign req_ready   = (state == S_IDLE);
  assign resp_valid  = (state == S_RESP);
  assign resp_rdata  = rdata_q;
  assign epc         = epc_q;
  assign status_exl  = exl;
  assign int_pending = ie & ~exl & (|(im & ip));

endmodule

// File: tb/tb_cop0_regfile.sv
// Self-checking bench for cop0_regfile: directed scenarios plus
// random traffic compared against a cycle-level reference model.
module tb_cop0_regfile;

  localparam int DIV = 2;
`ifdef COP0_TIMER_EN
  localparam bit TMR = 1'b1;
`else
  localparam bit TMR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [4:0]  req_addr = '0;
  logic [2:0]  req_sel = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_code = '0;
  logic [31:0] exc_pc = '0;
  logic        exc_in_delay = 1'b0;
  logic [31:0] exc_badvaddr = '0;
  logic        exc_badvaddr_valid = 1'b0;
  logic        eret_valid = 1'b0;
  logic [31:0] epc;
  logic [5:0]  hw_int = '0;
  logic        int_pending;
  logic        status_exl;

  int n_checks = 0;
  int n_fail = 0;

  cop0_regfile #(.COUNT_DIV(DIV)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_write          (req_write),
    .req_addr           (req_addr),
    .req_sel            (req_sel),
    .req_wdata          (req_wdata),
    .resp_valid         (resp_valid),
    .resp_ready         (resp_ready),
    .resp_rdata         (resp_rdata),
    .exc_valid          (exc_valid),
    .exc_code           (exc_code),
    .exc_pc             (exc_pc),
    .exc_in_delay       (exc_in_delay),
    .exc_badvaddr       (exc_badvaddr),
    .exc_badvaddr_valid (exc_badvaddr_valid),
    .eret_valid         (eret_valid),
    .epc                (epc),
    .hw_int             (hw_int),
    .int_pending        (int_pending),
    .status_exl         (status_exl)
  );

  always #5 clk = ~clk;

  // reference model state
  bit          m_busy;
  logic [31:0] m_rdata, m_epc, m_bva, m_count, m_compare;
  logic [7:0]  m_im;
  bit          m_ie, m_exl, m_bd, m_ti;
  logic [4:0]  m_code;
  logic [1:0]  m_ipsw;
  logic [5:0]  m_hw;
  int          m_div;

  task automatic model_reset();
    m_busy = 0; m_rdata = 0; m_epc = 0; m_bva = 0;
    m_count = 0; m_compare = 0; m_im = 0; m_ie = 0;
    m_exl = 0; m_bd = 0; m_ti = 0; m_code = 0;
    m_ipsw = 0; m_hw = 0; m_div = 0;
  endtask

  function automatic logic [7:0] model_ip();
    return {m_hw[5] | m_ti, m_hw[4:0], m_ipsw};
  endfunction

  function automatic logic [31:0] model_read(
    input logic [4:0] a, input logic [2:0] s);
    if (s != 3'd0) return 32'd0;
    case (a)
      5'd8:  return m_bva;
      5'd9:  return TMR ? m_count : 32'd0;
      5'd11: return TMR ? m_compare : 32'd0;
      5'd12: return 32'h0040_0000 | (32'(m_im) << 8)
                    | (32'(m_exl) << 1) | 32'(m_ie);
      5'd13: return (32'(m_bd) << 31) | (32'(m_ti) << 30)
                    | (32'(model_ip()) << 8) | (32'(m_code) << 2);
      5'd14: return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit model_int();
    return m_ie && !m_exl && ((m_im & model_ip()) != 8'd0);
  endfunction

  function automatic bit hit(input logic [4:0] a);
    return req_addr == a && req_sel == 3'd0;
  endfunction

  // one clock: inputs held across the edge, model advanced after it
  task automatic step();
    bit acc, wr, inc;
    logic [31:0] rd, old_cmp;
    acc = req_valid && !m_busy;
    wr = acc && req_write;
    rd = wr ? 32'd0 : model_read(req_addr, req_sel);
    @(posedge clk); #1;
    if (TMR) begin
      inc = 0;
      old_cmp = m_compare;
      if (wr && hit(5'd9)) begin
        m_count = req_wdata; m_div = 0;
      end else begin
        m_div++;
        if (m_div == DIV) begin
          m_div = 0; m_count = m_count + 1; inc = 1;
        end
      end
      if (wr && hit(5'd11)) begin
        m_compare = req_wdata; m_ti = 0;
      end else if (inc && m_count == old_cmp) begin
        m_ti = 1;
      end
    end
    if (wr && hit(5'd12)) begin
      m_im = req_wdata[15:8]; m_ie = req_wdata[0];
    end
    if (wr && hit(5'd13)) m_ipsw = req_wdata[9:8];
    if (exc_valid) begin
      if (!m_exl) begin
        m_epc = exc_in_delay ? exc_pc - 4 : exc_pc;
        m_bd = exc_in_delay;
      end
      m_code = exc_code;
      m_exl = 1;
      if (exc_badvaddr_valid) m_bva = exc_badvaddr;
    end else begin
      if (eret_valid) m_exl = 0;
      else if (wr && hit(5'd12)) m_exl = req_wdata[1];
      if (wr && hit(5'd14)) m_epc = req_wdata;
    end
    m_hw = hw_int;
    if (acc) begin
      m_busy = 1; m_rdata = rd;
    end else if (m_busy && resp_ready) begin
      m_busy = 0;
    end
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    req_valid = 1; req_write = 1; req_addr = a;
    req_sel = 0; req_wdata = d;
    step();
    req_valid = 0; resp_ready = 1;
    step();
    resp_ready = 0;
  endtask

  task automatic mfc0(input logic [4:0] a,
                      output logic [31:0] d, output logic v);
    req_valid = 1; req_write = 0; req_addr = a; req_sel = 0;
    step();
    req_valid = 0;
    v = resp_valid; d = resp_rdata;
    resp_ready = 1;
    step();
    resp_ready = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v;
    resetn = 0;
    model_reset();
    #12;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready);
    end
    n_checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_resp got %b/%h want 0/0", resp_valid, resp_rdata);
    end
    n_checks++;
    if (epc !== 32'd0 || status_exl !== 1'b0 || int_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got epc=%h exl=%b int=%b want 0",
               epc, status_exl, int_pending);
    end
    #1 resetn = 1;
    mfc0(5'd12, d, v);
    n_checks++;
    if (d !== 32'h0040_0000) begin
      n_fail++; $display("FAIL reset_status got %h want 00400000", d);
    end
  endtask

  task automatic test_status_rw();
    logic [31:0] d; logic v;
    mtc0(5'd8, 32'h0000_dead);
    mfc0(5'd8, d, v);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++; $display("FAIL badvaddr_ro got %h want 0", d);
    end
    mtc0(5'd12, 32'hFFFF_FFFF);
    mfc0(5'd12, d, v);
    n_checks++;
    if (v !== 1'b1) begin
      n_fail++; $display("FAIL status_latency resp_valid got %b want 1", v);
    end
    n_checks++;
    if (d !== 32'h0040_FF03) begin
      n_fail++; $display("FAIL status_mask got %h want 0040ff03", d);
    end
    mtc0(5'd13, 32'hFFFF_FFFF);
    mfc0(5'd13, d, v);
    n_checks++;
    if (d !== 32'h0000_0300) begin
      n_fail++; $display("FAIL cause_mask got %h want 00000300", d);
    end
    mfc0(5'd5, d, v);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++; $display("FAIL unimpl_read got %h want 0", d);
    end
    mtc0(5'd13, 32'd0);
    mtc0(5'd12, 32'd0);
  endtask

  task automatic test_exception();
    logic [31:0] d; logic v;
    exc_valid = 1; exc_code = 5'd4; exc_pc = 32'h8000_0104;
    exc_in_delay = 1; exc_badvaddr = 32'h13; exc_badvaddr_valid = 1;
    step();
    exc_valid = 0; exc_in_delay = 0; exc_badvaddr_valid = 0;
    n_checks++;
    if (epc !== 32'h8000_0100) begin
      n_fail++; $display("FAIL exc_epc got %h want 80000100", epc);
    end
    n_checks++;
    if (status_exl !== 1'b1) begin
      n_fail++; $display("FAIL exc_exl got %b want 1", status_exl);
    end
    mfc0(5'd13, d, v);
    n_checks++;
    if (d[31] !== 1'b1 || d[6:2] !== 5'd4) begin
      n_fail++;
      $display("FAIL exc_cause got bd=%b code=%0d want 1/4", d[31], d[6:2]);
    end
    mfc0(5'd8, d, v);
    n_checks++;
    if (d !== 32'h13) begin
      n_fail++; $display("FAIL exc_badvaddr got %h want 13", d);
    end
  endtask

  task automatic test_nested_eret();
    logic [31:0] d; logic v;
    exc_valid = 1; exc_code = 5'd8; exc_pc = 32'h200;
    exc_in_delay = 0;
    step();
    exc_valid = 0;
    n_checks++;
    if (epc !== 32'h8000_0100) begin
      n_fail++; $display("FAIL nested_epc got %h want 80000100", epc);
    end
    mfc0(5'd13, d, v);
    n_checks++;
    if (d[31] !== 1'b1 || d[6:2] !== 5'd8) begin
      n_fail++;
      $display("FAIL nested_cause got bd=%b code=%0d want 1/8", d[31], d[6:2]);
    end
    eret_valid = 1;
    step();
    eret_valid = 0;
    n_checks++;
    if (status_exl !== 1'b0 || epc !== 32'h8000_0100) begin
      n_fail++;
      $display("FAIL eret got exl=%b epc=%h want 0/80000100", status_exl, epc);
    end
  endtask

  task automatic test_timer();
    logic [31:0] d; logic v;
    bit seen, prev;
    if (TMR) begin
      mtc0(5'd12, 32'h0000_8001);
      mtc0(5'd9, 32'h1000_0000);
      mtc0(5'd11, 32'd5);
      mtc0(5'd9, 32'd0);
      seen = 0;
      prev = int_pending;
      for (int i = 0; i < 40 && !seen; i++) begin
        step();
        n_checks++;
        if (int_pending !== model_int()) begin
          n_fail++;
          $display("FAIL timer_int cyc %0d got %b want %b",
                   i, int_pending, model_int());
        end
        if (m_ti) begin
          seen = 1;
          n_checks++;
          if (prev !== 1'b0 || int_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL timer_edge got %b->%b want 0->1", prev, int_pending);
          end
        end
        prev = int_pending;
      end
      n_checks++;
      if (!seen) begin
        n_fail++; $display("FAIL timer_timeout got no match want match");
      end
      mfc0(5'd13, d, v);
      n_checks++;
      if (d[30] !== 1'b1) begin
        n_fail++; $display("FAIL timer_ti got %b want 1", d[30]);
      end
      mtc0(5'd11, 32'h0100_0000);
      n_checks++;
      if (int_pending !== 1'b0) begin
        n_fail++; $display("FAIL timer_clear got %b want 0", int_pending);
      end
      mfc0(5'd13, d, v);
      n_checks++;
      if (d[30] !== 1'b0) begin
        n_fail++; $display("FAIL timer_ti_clr got %b want 0", d[30]);
      end
    end else begin
      mtc0(5'd9, 32'h1234);
      mtc0(5'd11, 32'd5);
      mfc0(5'd9, d, v);
      n_checks++;
      if (d !== 32'd0) begin
        n_fail++; $display("FAIL count_off got %h want 0", d);
      end
      mfc0(5'd11, d, v);
      n_checks++;
      if (d !== 32'd0) begin
        n_fail++; $display("FAIL compare_off got %h want 0", d);
      end
    end
    mtc0(5'd12, 32'd0);
  endtask

  task automatic test_backpressure();
    mtc0(5'd14, 32'hCAFE_0000);
    req_valid = 1; req_write = 0; req_addr = 5'd14; req_sel = 0;
    step();
    req_addr = 5'd12;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (resp_rdata !== 32'hCAFE_0000 || req_ready !== 1'b0
          || resp_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL hold cyc %0d got rd=%h rr=%b rv=%b want cafe0000/0/1",
                 i, resp_rdata, req_ready, resp_valid);
      end
      step();
    end
    req_valid = 0;
    #2 resetn = 0;
    #1;
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset got rv=%b rr=%b want 0/1", resp_valid, req_ready);
    end
    model_reset();
    #2 resetn = 1;
  endtask

  task automatic test_hw_int();
    mtc0(5'd12, 32'h0000_0401);
    hw_int = 6'b000001;
    step();
    n_checks++;
    if (int_pending !== 1'b1) begin
      n_fail++; $display("FAIL hw_int got %b want 1", int_pending);
    end
    exc_valid = 1; exc_code = 5'd0; exc_pc = 32'h400;
    step();
    exc_valid = 0;
    n_checks++;
    if (int_pending !== 1'b0) begin
      n_fail++; $display("FAIL hw_int_exl got %b want 0", int_pending);
    end
    eret_valid = 1;
    step();
    eret_valid = 0;
    hw_int = 0;
    step();
    n_checks++;
    if (int_pending !== 1'b0) begin
      n_fail++; $display("FAIL hw_int_drop got %b want 0", int_pending);
    end
  endtask

  task automatic test_random();
    logic [4:0] addrs [7];
    addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
    for (int i = 0; i < 500; i++) begin
      req_valid = ($urandom_range(0, 1) == 1);
      req_write = ($urandom_range(0, 1) == 1);
      req_addr = addrs[$urandom_range(0, 6)];
      req_sel = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd0;
      req_wdata = $urandom;
      resp_ready = ($urandom_range(0, 2) != 0);
      exc_valid = ($urandom_range(0, 15) == 0);
      exc_code = 5'($urandom);
      exc_pc = $urandom;
      exc_in_delay = ($urandom_range(0, 1) == 1);
      exc_badvaddr = $urandom;
      exc_badvaddr_valid = ($urandom_range(0, 1) == 1);
      eret_valid = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 7) == 0) hw_int = 6'($urandom);
      step();
      n_checks++;
      if (req_ready !== !m_busy || resp_valid !== m_busy) begin
        n_fail++;
        $display("FAIL rnd_fsm cyc %0d got rr=%b rv=%b want busy=%b",
                 i, req_ready, resp_valid, m_busy);
      end
      n_checks++;
      if (resp_rdata !== m_rdata) begin
        n_fail++;
        $display("FAIL rnd_rdata cyc %0d got %h want %h", i, resp_rdata, m_rdata);
      end
      n_checks++;
      if (epc !== m_epc || status_exl !== m_exl) begin
        n_fail++;
        $display("FAIL rnd_exc cyc %0d got epc=%h exl=%b want %h/%b",
                 i, epc, status_exl, m_epc, m_exl);
      end
      n_checks++;
      if (int_pending !== model_int()) begin
        n_fail++;
        $display("FAIL rnd_int cyc %0d got %b want %b",
                 i, int_pending, model_int());
      end
    end
    req_valid = 0; exc_valid = 0; eret_valid = 0; resp_ready = 0;
  endtask

  initial begin
    test_reset();
    test_status_rw();
    test_exception();
    test_nested_eret();
    test_timer();
    test_backpressure();
    test_hw_int();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
